mem_wbuf: RTL and testbench

Posted write buffer that sits directly downstream of the memory cache, between the cache's write-back path and the backing memory port. It accepts writes (address, data, byte enables) from the cache and holds them in a FIFO of `DEPTH` entries. It drains them in order to memory over a valid/ready port. It also provides a same-cycle lookup so the cache's refill path can forward buffered data or detect a hazard.

---
 rtl/mem_wbuf_pkg.sv | 18 +
 rtl/mem_wbuf_if.sv | 35 +++
 rtl/mem_wbuf_lookup.sv | 36 +++
 rtl/mem_wbuf.sv | 86 ++++++++
 tb/tb_mem_wbuf.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_wbuf_pkg.sv
// mem_wbuf_pkg: shared mem types for the posted write buffer (entry struct, width helpers).
package mem_wbuf_pkg;
  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_DEPTH = 4;
  function automatic int be_w(input int dw);
    return dw / 8;
  endfunction
  function automatic bit data_w_ok(input int dw);
    return dw > 0 && dw % 8 == 0;
  endfunction
  localparam int WB_BE_W = be_w(WB_DATA_W);
  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
    logic [WB_BE_W-1:0] be;
  } mem_wbuf_entry_t;
endpackage

// File: rtl/mem_wbuf_if.sv
// mem_wbuf_if: cache write port, memory drain port and refill lookup of the write buffer.
interface mem_wbuf_if
  import mem_wbuf_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W,
  parameter int DEPTH = WB_DEPTH
);
  localparam int BE_W = be_w(DATA_W);
  localparam int CW = $clog2(DEPTH + 1);
  logic in_valid;
  logic in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic [BE_W-1:0] in_be;
  logic mem_valid;
  logic mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [BE_W-1:0] mem_be;
  logic [ADDR_W-1:0] lk_addr;
  logic lk_hit;
  logic lk_partial;
  logic [DATA_W-1:0] lk_data;
  logic [CW-1:0] count;
  logic empty;
  modport slave (
    input in_valid, in_addr, in_data, in_be, mem_ready, lk_addr,
    output in_ready, mem_valid, mem_addr, mem_data, mem_be, lk_hit, lk_partial, lk_data, count, empty
  );
  modport master (
    output in_valid, in_addr, in_data, in_be, mem_ready, lk_addr,
    input in_ready, mem_valid, mem_addr, mem_data, mem_be, lk_hit, lk_partial, lk_data, count, empty
  );
endinterface

// File: rtl/mem_wbuf_lookup.sv
// mem_wbuf_lookup: combinational youngest-first address match over the valid buffer entries.
module mem_wbuf_lookup
  import mem_wbuf_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input mem_wbuf_entry_t ents [DEPTH],
  input logic [DEPTH-1:0] vld,
  input logic [$clog2(DEPTH)-1:0] rptr,
  input logic [WB_ADDR_W-1:0] lk_addr,
  output logic lk_hit,
  output logic lk_partial,
  output logic [WB_DATA_W-1:0] lk_data
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] idx;
  logic found;
  logic [WB_BE_W-1:0] be;
  // walk oldest to youngest so the last match wins
  always_comb begin
    found = 1'b0;
    be = '0;
    lk_data = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr + PW'(k);
      if (vld[idx] && ents[idx].addr == lk_addr) begin
        found = 1'b1;
        be = ents[idx].be;
        lk_data = ents[idx].data;
      end
    end
  end
  assign lk_hit = found && (&be);
  assign lk_partial = found && !(&be);
endmodule

// File: rtl/mem_wbuf.sv
// mem_wbuf: posted write buffer between cache write-back and memory, in-order drain plus lookup.
// Optional write coalescing into the youngest entry with MEM_WBUF_COALESCE_EN.
module mem_wbuf
  import mem_wbuf_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W,
  parameter int DEPTH = WB_DEPTH
) (
  input logic clk,
  input logic rst_n,
  mem_wbuf_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int BE_W = be_w(DATA_W);
  if (ADDR_W != WB_ADDR_W || DATA_W != WB_DATA_W || !data_w_ok(DATA_W) || DEPTH < 2 || (1 << PW) != DEPTH)
    $error("mem_wbuf: widths must match mem_wbuf_pkg and DEPTH must be a power of 2");
  mem_wbuf_entry_t ents [DEPTH];
  mem_wbuf_entry_t head;
  logic [PW:0] wptr, rptr, cnt;
  logic [PW-1:0] age, yidx;
  logic [DEPTH-1:0] vld;
  logic full, push, pop, alloc;
  assign cnt = wptr - rptr;
  assign full = (wptr ^ rptr) == {1'b1, {PW{1'b0}}};
  assign bus.empty = wptr == rptr;
  assign bus.count = cnt;
  assign bus.in_ready = !full;
  assign bus.mem_valid = !bus.empty;
  assign push = bus.in_valid && !full;
  assign pop = bus.mem_valid && bus.mem_ready;
  assign yidx = wptr[PW-1:0] - PW'(1);
  assign head = bus.empty ? '0 : ents[rptr[PW-1:0]];
  assign bus.mem_addr = head.addr;
  assign bus.mem_data = head.data;
  assign bus.mem_be = head.be;
`ifdef MEM_WBUF_COALESCE_EN
  logic merge;
  logic [DATA_W-1:0] mdata;
  // count >= 2 keeps the presented head untouched
  assign merge = push && cnt >= (PW + 1)'(2) && ents[yidx].addr == bus.in_addr;
  assign alloc = push && !merge;
  always_comb begin
    mdata = '0;
    for (int b = 0; b < BE_W; b++)
      mdata[8*b+:8] = bus.in_be[b] ? bus.in_data[8*b+:8] : ents[yidx].data[8*b+:8];
  end
`else
  assign alloc = push;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (alloc) wptr <= wptr + (PW + 1)'(1);
      if (pop) rptr <= rptr + (PW + 1)'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (alloc) ents[wptr[PW-1:0]] <= '{addr: bus.in_addr, data: bus.in_data, be: bus.in_be};
`ifdef MEM_WBUF_COALESCE_EN
    if (merge) begin
      ents[yidx].data <= mdata;
      ents[yidx].be <= ents[yidx].be | bus.in_be;
    end
`endif
  end
  always_comb begin
    vld = '0;
    age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age = PW'(i) - rptr[PW-1:0];
      vld[i] = {1'b0, age} < cnt;
    end
  end
  mem_wbuf_lookup #(.DEPTH(DEPTH)) u_lookup (
    .ents(ents),
    .vld(vld),
    .rptr(rptr[PW-1:0]),
    .lk_addr(bus.lk_addr),
    .lk_hit(bus.lk_hit),
    .lk_partial(bus.lk_partial),
    .lk_data(bus.lk_data)
  );
endmodule

// File: tb/tb_mem_wbuf.sv
// tb_mem_wbuf: queue-model checked bench for mem_wbuf with directed and random traffic.
module tb_mem_wbuf;
  import mem_wbuf_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int pass_cnt = 0;
  int total_cnt = 0;
  mem_wbuf_entry_t q[$];
  mem_wbuf_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) bus ();
  mem_wbuf #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // reference: a queue of writes, oldest at the front
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q.delete();
    else begin
      automatic int n = q.size();
      automatic bit do_push = bus.in_valid && n < DEPTH;
      automatic bit do_pop = n > 0 && bus.mem_ready;
      automatic bit merged = 1'b0;
`ifdef MEM_WBUF_COALESCE_EN
      if (do_push && n >= 2 && q[n-1].addr == bus.in_addr) begin
        for (int b = 0; b < 4; b++)
          if (bus.in_be[b]) q[n-1].data[8*b+:8] = bus.in_data[8*b+:8];
        q[n-1].be = q[n-1].be | bus.in_be;
        merged = 1'b1;
      end
`endif
      if (do_pop) void'(q.pop_front());
      if (do_push && !merged) q.push_back('{addr: bus.in_addr, data: bus.in_data, be: bus.in_be});
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      automatic int n = q.size();
      automatic mem_wbuf_entry_t hd = n > 0 ? q[0] : '0;
      automatic mem_wbuf_entry_t m = '0;
      automatic bit found = 1'b0;
      for (int i = n - 1; i >= 0; i--)
        if (q[i].addr == bus.lk_addr) begin
          m = q[i];
          found = 1'b1;
          break;
        end
      chk("count", 64'(bus.count), 64'(n));
      chk("empty", 64'(bus.empty), 64'(n == 0));
      chk("in_ready", 64'(bus.in_ready), 64'(n < DEPTH));
      chk("mem_valid", 64'(bus.mem_valid), 64'(n > 0));
      chk("mem_addr", 64'(bus.mem_addr), 64'(hd.addr));
      chk("mem_data", 64'(bus.mem_data), 64'(hd.data));
      chk("mem_be", 64'(bus.mem_be), 64'(hd.be));
      chk("lk_hit", 64'(bus.lk_hit), 64'(found && m.be == 4'hF));
      chk("lk_partial", 64'(bus.lk_partial), 64'(found && m.be != 4'hF));
      chk("lk_data", 64'(bus.lk_data), 64'(m.data));
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.in_valid = 1'b1;
    bus.in_addr = a;
    bus.in_data = d;
    bus.in_be = be;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 50 && !bus.empty; i++) @(negedge clk);
    chk("drain_empty", 64'(bus.empty), 64'd1);
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_addr = '0;
    bus.in_data = '0;
    bus.in_be = '0;
    bus.mem_ready = 1'b0;
    bus.lk_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_lk_data", 64'(bus.lk_data), 64'd0);
    // fill and stall
    for (int i = 0; i < 4; i++) push(32'h10 + 32'(i), 32'hD000 + 32'(i), 4'hF);
    @(negedge clk);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_count", 64'(bus.count), 64'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_addr", 64'(bus.mem_addr), 64'h10);
    end
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 64'(bus.mem_addr), 64'h10 + 64'(i));
      @(negedge clk);
    end
    bus.mem_ready = 1'b0;
    chk("drained_empty", 64'(bus.empty), 64'd1);
    // reset mid-drain with three entries
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) push(32'h60 + 32'(i), 32'h600 + 32'(i), 4'hF);
    bus.lk_addr = 32'h61;
    bus.mem_ready = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_count", 64'(bus.count), 64'd0);
    chk("mid_rst_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_lk_hit", 64'(bus.lk_hit), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.mem_ready = 1'b0;
    // simultaneous push and pop at count 2
    push(32'h80, 32'h800, 4'hF);
    push(32'h81, 32'h801, 4'hF);
    bus.in_valid = 1'b1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_addr = 32'h82 + 32'(i);
      bus.in_data = 32'h802 + 32'(i);
      @(negedge clk);
      chk("pushpop_count", 64'(bus.count), 64'd2);
      chk("pushpop_head", 64'(bus.mem_addr), 64'h80 + 64'(i));
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    drain();
    // lookup priority
    push(32'h20, 32'hAAAA_AAAA, 4'hF);
    push(32'h20, 32'h5555_5555, 4'hF);
    bus.lk_addr = 32'h20;
    @(negedge clk);
    chk("lk_young_hit", 64'(bus.lk_hit), 64'd1);
    chk("lk_young_data", 64'(bus.lk_data), 64'h5555_5555);
    push(32'h30, 32'h0000_BEEF, 4'h3);
    bus.lk_addr = 32'h30;
    @(negedge clk);
    chk("lk_part_partial", 64'(bus.lk_partial), 64'd1);
    chk("lk_part_hit", 64'(bus.lk_hit), 64'd0);
    drain();
    // coalesce at count 2, then the same push at count 1
    push(32'h50, 32'h0505_0505, 4'hF);
    push(32'h40, 32'h1122_3344, 4'h3);
    push(32'h40, 32'hAABB_0000, 4'hC);
    @(negedge clk);
`ifdef MEM_WBUF_COALESCE_EN
    chk("coal_count", 64'(bus.count), 64'd2);
`else
    chk("coal_count", 64'(bus.count), 64'd3);
`endif
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1 bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("coal_addr", 64'(bus.mem_addr), 64'h40);
`ifdef MEM_WBUF_COALESCE_EN
    chk("coal_data", 64'(bus.mem_data), 64'hAABB_3344);
    chk("coal_be", 64'(bus.mem_be), 64'hF);
`else
    chk("coal_data", 64'(bus.mem_data), 64'h1122_3344);
    chk("coal_be", 64'(bus.mem_be), 64'h3);
`endif
    drain();
    push(32'h40, 32'h1122_3344, 4'h3);
    push(32'h40, 32'hAABB_0000, 4'hC);
    @(negedge clk);
    chk("coal_cnt1_count", 64'(bus.count), 64'd2);
    drain();
    // random traffic with wrap-around and lookups
    @(posedge clk);
    #1;
    for (int i = 0; i < 200; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_addr = 32'h70 + 32'($urandom_range(0, 3));
      bus.in_data = $urandom;
      bus.in_be = 4'($urandom_range(1, 15));
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.lk_addr = 32'h70 + 32'($urandom_range(0, 4));
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    drain();
    @(negedge clk);
    chk("final_empty", 64'(bus.empty), 64'd1);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
